// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if
//   Bundles the signals around the register-file write port arbiter:
//   - wb_*       : instruction leaving MEM/WB (pipeline write-back request)
//   - lu_*       : valid/ready handshake from the long-latency unit
//   - rf_*       : register-file write port
//   - pipe_stall : one-cycle freeze request to the pipeline
//   - pend_mask  : destinations currently held in the arbiter's buffer
//   master = pipeline/long-latency side (drives requests),
//   slave  = arbiter side (drives the write port and status).
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_o;
  logic [4:0]  wb_rd;
  logic        wb_mem2reg;
  logic        wb_regs_write;

  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        pipe_stall;
  logic [31:0] pend_mask;

  modport master (
    output wb_mem_data, wb_alu_o, wb_rd, wb_mem2reg, wb_regs_write,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_mask
  );

  modport slave (
    input  wb_mem_data, wb_alu_o, wb_rd, wb_mem2reg, wb_regs_write,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order
//   write-back stage and a long-latency unit. Long-latency results are held
//   in a 2-entry FIFO and written in idle write-back slots; a head entry that
//   stays blocked for STARVE_LIMIT cycles freezes the pipeline for one cycle
//   to force its write.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : wb_port_arbiter_if.slave (wb_* in, lu_* handshake, rf_* out,
//          pipe_stall, pend_mask)
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STEAL = 2'd2
  } state_e;

  localparam logic [3:0] AGE_MAX = 4'(STARVE_LIMIT - 1);

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [3:0]  age_q, age_d;
  logic        pipe_stall_q, pipe_stall_d;

  // FIFO payload carries no reset: occupancy is tracked by count_q alone.
  logic [4:0]  fifo_rd_q   [2];
  logic [31:0] fifo_data_q [2];

  logic slot_busy, in_steal, has_head, lu_ready_c;
  logic push, pop, grant_pipe;

  always_comb begin
    slot_busy  = bus.wb_regs_write && (bus.wb_rd != 5'd0);
    in_steal   = (state_q == ST_STEAL);
    has_head   = (count_q != 2'd0);
    // Ready looks at the pre-edge count: a full FIFO refuses even if it pops.
    lu_ready_c = !rst && (count_q != 2'd2);
    // x0 results complete the handshake but are dropped.
    push       = bus.lu_valid && lu_ready_c && (bus.lu_rd != 5'd0);
    pop        = !rst && has_head && (in_steal || !slot_busy);
    grant_pipe = !rst && !in_steal && slot_busy;
  end

  // Write-port mux
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    if (pop) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = fifo_rd_q[head_q];
      bus.rf_wdata = fifo_data_q[head_q];
    end else if (grant_pipe) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.wb_rd;
      bus.rf_wdata = bus.wb_mem2reg ? bus.wb_mem_data : bus.wb_alu_o;
    end
  end

  always_comb begin
    bus.lu_ready   = lu_ready_c;
    bus.pipe_stall = pipe_stall_q;
    bus.pend_mask  = 32'd0;
    if (count_q != 2'd0) bus.pend_mask[fifo_rd_q[head_q]]  = 1'b1;
    if (count_q == 2'd2) bus.pend_mask[fifo_rd_q[~head_q]] = 1'b1;
    bus.pend_mask[0] = 1'b0;
  end

  // Next-state for pointers, age and FSM
  always_comb begin
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    head_d       = pop  ? ~head_q : head_q;
    tail_d       = push ? ~tail_q : tail_q;
    age_d        = age_q;
    state_d      = state_q;
    pipe_stall_d = 1'b0;

    if (pop || !has_head) begin
      age_d = 4'd0;
    end else if (state_q == ST_WAIT) begin
      age_d = age_q + 4'd1;
    end

    case (state_q)
      ST_STEAL: begin
        // Never chains into another steal; a remaining entry restarts at age 0.
        state_d = (count_d != 2'd0) ? ST_WAIT : ST_IDLE;
      end
      default: begin
        if ((state_q == ST_WAIT) && has_head && !pop && (age_q == AGE_MAX)) begin
          state_d      = ST_STEAL;
          pipe_stall_d = 1'b1;
        end else begin
          state_d = (count_d != 2'd0) ? ST_WAIT : ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= 2'd0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      age_q        <= 4'd0;
      pipe_stall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      age_q        <= age_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[tail_q]   <= bus.lu_rd;
      fifo_data_q[tail_q] <= bus.lu_data;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline's write-back stage (fed by the MEM/WB pipeline register) and an out-of-band long-latency unit (multi-cycle mul/div or uncached load). It buffers long-latency results in a 2-entry FIFO and drains them into idle write-back slots. If a buffered result waits too long, it requests a one-cycle pipeline freeze to force its write. It sits between the MEM/WB register and the register file and also drives a pending-destination mask to the hazard unit.

## Interface
- STARVE_LIMIT, 4: blocked cycles a buffered result may wait before a steal is requested; legal range 1..15.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- wb_mem_data  in  32  load data from MEM/WB.
- wb_alu_o  in  32  ALU result from MEM/WB.
- wb_rd  in  5  destination from MEM/WB.
- wb_mem2reg  in  1  1 selects wb_mem_data, 0 selects wb_alu_o.
- wb_regs_write  in  1  pipeline write request.
- lu_valid  in  1  long-latency result offered.
- lu_ready  out  1  arbiter accepts lu result this cycle.
- lu_rd  in  5  long-latency destination.
- lu_data  in  32  long-latency result.
- rf_we  out  1  register-file write enable (combinational).
- rf_waddr  out  5  register-file write address (combinational).
- rf_wdata  out  32  register-file write data (combinational).
- pipe_stall  out  1  registered freeze request to the pipeline (MEM/WB and upstream hold).
- pend_mask  out  32  bit n set while any buffered entry targets xn; bit 0 always 0.

## Operation
- Pipeline slot busy: wb_regs_write=1 and wb_rd!=0. Otherwise the slot is idle.
- FIFO: 2 entries {rd, data}, with head and tail pointers and a 2-bit count.
  - lu_ready = !rst && count<2. It is evaluated on the pre-edge count, so a full FIFO refuses even if it pops in the same cycle.
  - Handshake: lu_valid && lu_ready. An entry with lu_rd=0 is accepted and discarded, never enqueued.
- Grant mux, priority order:
  - state STEAL → buffer head;
  - else slot busy → pipeline;
  - else count>0 → buffer head;
  - else no write.
- Outputs per grant:
  - Pipeline: rf_we=1, rf_waddr=wb_rd, rf_wdata = wb_mem2reg ? wb_mem_data : wb_alu_o.
  - Head: rf_we=1, rf_waddr=head.rd, rf_wdata=head.data, and the head pops at the clock edge.
  - None: rf_we=0, rf_waddr=0, rf_wdata=0.
- In STEAL, the wb_* inputs are ignored. The pipeline is frozen, and its instruction is presented again the next cycle.
- age counter, 4 bits:
  - cleared on any pop and whenever count=0;
  - increments each cycle the head exists but the pipeline holds the port (state WAIT).
- States:
  - IDLE: count=0, or the head drains this cycle. If an entry remains blocked after the edge → WAIT.
  - WAIT: if the head drains in an idle slot → IDLE (count becomes 0) or stay in WAIT with age=0 (count becomes 1). If blocked and age==STARVE_LIMIT-1 → STEAL, with pipe_stall←1 at that edge.
  - STEAL: pipe_stall=1 for exactly this cycle and the head is written unconditionally. Next state is WAIT if an entry remains, else IDLE. pipe_stall←0, so back-to-back steals never occur; a second entry restarts at age 0.
- The arbiter does not reorder same-rd writes. RAW/WAW ordering against pend_mask is the hazard unit's responsibility.
- Simultaneous enqueue and pop: both happen and count is unchanged. An entry enqueued in cycle t is writable no earlier than t+1.

## Timing
- Reset (asynchronous, while rst=1 and on release):
  - FIFO empty, age=0, state IDLE;
  - pipe_stall=0, lu_ready=0, pend_mask=0;
  - rf_we=0, rf_waddr=0, rf_wdata=0 (grant suppressed during reset).
- Reset mid-operation drops buffered entries without writing them, and pipe_stall falls immediately.
- Pipeline write latency: 0 cycles (combinational pass-through).
- Buffered write latency: minimum 1 cycle after accept. Maximum STARVE_LIMIT+1 cycles after reaching the head under a continuously busy pipeline.
- pend_mask updates one cycle after the accept or pop edge, because it is decoded from the registered FIFO.

## Test plan
- Pipeline only: wb_regs_write=1, wb_rd=5, wb_mem2reg=1, wb_mem_data=0xDEADBEEF → rf_we=1, waddr=5, wdata=0xDEADBEEF in the same cycle; pipe_stall stays 0.
- Idle-slot drain: accept lu_rd=7, lu_data=0x12345678 with wb_regs_write=0 → next cycle write x7=0x12345678; pend_mask bit 7 is set for exactly one cycle.
- Starvation, STARVE_LIMIT=4: enqueue rd=9 with the pipeline busy every cycle → pipe_stall=1 in the 5th cycle after the accept; the x9 write occurs that cycle; the pipeline's rd write occurs the following cycle; pipe_stall=0 again.
- Full FIFO: accept two entries (rd 3, rd 4) under a busy pipeline → lu_ready=0. A third lu_valid is held until a pop. rd 3 steals first; rd 4 steals no earlier than STARVE_LIMIT cycles later.
- x0 handling: lu_rd=0 accepted → count stays 0 and no write occurs. wb_regs_write=1 with wb_rd=0 and one buffered entry → the buffered entry wins the port.
- Reset mid-steal: assert rst during STEAL → pipe_stall, rf_we, and lu_ready go to 0 asynchronously; pend_mask=0; no write occurs after release.
